afifo_rd_adapter: RTL and testbench

AFIFO_RD_ADAPTER -- requirements
Module: afifo_rd_adapter

---
 rtl/afifo_pkg.sv | 20 ++
 rtl/afifo_rd_adapter_if.sv | 32 +++
 rtl/rd_skid_buf.sv | 61 ++++++
 rtl/afifo_rd_adapter.sv | 97 +++++++++
 tb/tb_afifo_rd_adapter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/afifo_pkg.sv
// Shared definitions for the async-FIFO read-side adapter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package afifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  // Occupancy of the 2-entry output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // Words held or already requested: buffered entries plus the read in flight.
  function automatic logic [1:0] occ_lvl(input occ_e occ, input logic inflight);
    return 2'(occ) + {1'b0, inflight};
  endfunction

endpackage

// File: rtl/afifo_rd_adapter_if.sv
// Bundle of the AFIFO read-port signals and the valid/ready output stream.
// Latency: n/a (wires only).
// Backpressure: m_ready from the consumer; fifo_rd_en is the only pull towards the AFIFO.
interface afifo_rd_adapter_if
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
);

  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  flush;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic [CNT_WIDTH-1:0]  pop_cnt;

  // Adapter side.
  modport master (
    input  fifo_empty, fifo_rdata, flush, m_ready,
    output fifo_rd_en, m_valid, m_data, pop_cnt
  );

  // AFIFO plus consumer side.
  modport slave (
    output fifo_empty, fifo_rdata, flush, m_ready,
    input  fifo_rd_en, m_valid, m_data, pop_cnt
  );

endinterface

// File: rtl/rd_skid_buf.sv
// Two-entry in-order data store (head/tail); occupancy is owned by the caller.
// Latency: a push is visible at head_dat on the edge after it, when the buffer was empty.
// Backpressure: none locally; the caller never pushes into a full buffer without a pop.
module rd_skid_buf
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_rd,
  input  logic                  rst_rd_n,
  input  occ_e                  occ,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_dat,
  output logic [DATA_WIDTH-1:0] head_dat
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;

  // Place a pushed word behind whatever remains after this cycle's pop.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    case (occ)
      EMPTY: begin
        if (push) head_d = push_dat;
      end
      ONE: begin
        if (pop) begin
          if (push) head_d = push_dat;
        end else if (push) begin
          tail_d = push_dat;
        end
      end
      TWO: begin
        if (pop) begin
          head_d = tail_q;
          if (push) tail_d = push_dat;
        end
      end
      default: begin
        head_d = head_q;
      end
    endcase
  end

  // Storage registers; cleared so m_data reads zero out of reset.
  always_ff @(posedge clk_rd or negedge rst_rd_n) begin
    if (!rst_rd_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign head_dat = head_q;

endmodule

// File: rtl/afifo_rd_adapter.sv
// Turns the 1-cycle-latency AFIFO read port into a valid/ready stream via a 2-entry buffer.
// Latency: rd_en in cycle N, word captured at edge N+1, m_valid from then; 1 word/cycle sustained.
// Backpressure: m_ready low stalls m_data; reads stop once buffered + in-flight reaches 2.
module afifo_rd_adapter
  import afifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input logic               clk_rd,
  input logic               rst_rd_n,
  afifo_rd_adapter_if.master bus
);

  occ_e                 occ_q, occ_d;
  logic                 m_valid_q;
  logic                 inflight_q, inflight_d;
  logic                 run_q, run_d;
  logic [CNT_WIDTH-1:0] pop_cnt_q, pop_cnt_d;
  logic [1:0]           lvl;
  logic                 hs;
  logic                 capture;
  logic                 rd_en;

  // Handshake, capture and pop-request decisions; flush overrides all of them.
  always_comb begin
    lvl     = occ_lvl(occ_q, inflight_q);
    hs      = m_valid_q && bus.m_ready && !bus.flush;
    capture = inflight_q && !bus.flush;
    // run_q holds reads off until the first edge after reset release.
    rd_en   = run_q && !bus.fifo_empty && !bus.flush &&
              ((lvl < 2'd2) || ((lvl == 2'd2) && m_valid_q && bus.m_ready));
    inflight_d = rd_en;
    run_d      = 1'b1;
    pop_cnt_d  = pop_cnt_q;
    if (hs) pop_cnt_d = pop_cnt_q + CNT_WIDTH'(1);
  end

  // Next occupancy: +1 per capture, -1 per handshake, EMPTY on flush.
  always_comb begin
    occ_d = occ_q;
    if (bus.flush) begin
      occ_d = EMPTY;
    end else begin
      case (occ_q)
        EMPTY: if (capture) occ_d = ONE;
        ONE: begin
          if (capture && !hs) occ_d = TWO;
          else if (!capture && hs) occ_d = EMPTY;
        end
        TWO: if (hs && !capture) occ_d = ONE;
        default: occ_d = EMPTY;
      endcase
    end
  end

  // Occupancy FSM with m_valid registered alongside it.
  always_ff @(posedge clk_rd or negedge rst_rd_n) begin
    if (!rst_rd_n) begin
      occ_q     <= EMPTY;
      m_valid_q <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      m_valid_q <= (occ_d != EMPTY);
    end
  end

  // In-flight flag, read enable arming and delivered-word counter.
  always_ff @(posedge clk_rd or negedge rst_rd_n) begin
    if (!rst_rd_n) begin
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
      pop_cnt_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      run_q      <= run_d;
      pop_cnt_q  <= pop_cnt_d;
    end
  end

  rd_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk_rd  (clk_rd),
    .rst_rd_n(rst_rd_n),
    .occ     (occ_q),
    .push    (capture),
    .pop     (hs),
    .push_dat(bus.fifo_rdata),
    .head_dat(bus.m_data)
  );

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = m_valid_q;
  assign bus.pop_cnt    = pop_cnt_q;

endmodule

// File: tb/tb_afifo_rd_adapter.sv
// Bench for afifo_rd_adapter: queue-based AFIFO model plus an in-order stream reference.
// Latency: checks the 2-edge fill latency and back-to-back delivery.
// Backpressure: exercises held m_ready, alternating m_ready and random stalls.
module tb_afifo_rd_adapter;

  logic clk = 1'b0;
  logic rst_n;
  logic rst4_n;

  always #5 clk = ~clk;

  afifo_rd_adapter_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();
  afifo_rd_adapter_if #(.DATA_WIDTH(8),  .CNT_WIDTH(4))  bus4 ();

  afifo_rd_adapter #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_rd  (clk),
    .rst_rd_n(rst_n),
    .bus     (bus)
  );

  afifo_rd_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk_rd  (clk),
    .rst_rd_n(rst4_n),
    .bus     (bus4)
  );

  int checks = 0;
  int errors = 0;

  // Reference: words still in the AFIFO, and words read out but not yet delivered, in order.
  logic [31:0] fifo_q[$];
  logic [31:0] held[$];
  bit          inflight_prev;
  bit          armed;
  bit          force_empty;
  int          model_cnt;
  int          cycle_no;
  bit          prev_mv, prev_rdy, prev_flush;
  logic [31:0] prev_md;
  bit          last_rd, last_mv, last_hs;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; sample at negedge, advance model after posedge.
  task automatic cyc();
    bit          exp_mv, exp_rd, mv, rd, hs;
    logic [31:0] md, w;
    int          vis;
    bus.fifo_empty = (fifo_q.size() == 0) || force_empty;
    @(negedge clk);
    cycle_no++;
    vis    = held.size() - int'(inflight_prev);
    exp_mv = (vis > 0);
    exp_rd = armed && rst_n && !bus.fifo_empty && !bus.flush &&
             ((held.size() < 2) || ((held.size() == 2) && exp_mv && bus.m_ready));
    mv = bus.m_valid;
    rd = bus.fifo_rd_en;
    md = bus.m_data;
    chk("rd_en", 64'(rd), 64'(exp_rd));
    chk("m_valid", 64'(mv), 64'(exp_mv));
    if (exp_mv) chk("m_data", 64'(md), 64'(held[0]));
    if (prev_mv && !prev_rdy && !prev_flush) chk("hold_data", 64'(md), 64'(prev_md));
    chk("pop_cnt", 64'(bus.pop_cnt), 64'(model_cnt % 65536));
    hs = exp_mv && bus.m_ready && !bus.flush;
    prev_mv = mv; prev_rdy = bus.m_ready; prev_flush = bus.flush; prev_md = md;
    last_rd = rd; last_mv = mv; last_hs = hs;
    @(posedge clk);
    #1;
    if (bus.flush) held.delete();
    else if (hs) begin
      void'(held.pop_front());
      model_cnt++;
    end
    inflight_prev = 1'b0;
    if (rd && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      held.push_back(w);
      bus.fifo_rdata = w;
      inflight_prev = 1'b1;
    end else begin
      bus.fifo_rdata = $urandom;
    end
    armed = rst_n;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rd, first_mv, first_hs, last_hs_c, n_hs, n_rd, cnt_before, n4;
    logic [31:0] bp0;

    rst_n = 1'b0; rst4_n = 1'b0;
    bus.fifo_empty = 1'b1; bus.fifo_rdata = '0; bus.flush = 1'b0; bus.m_ready = 1'b0;
    bus4.fifo_empty = 1'b1; bus4.fifo_rdata = '0; bus4.flush = 1'b0; bus4.m_ready = 1'b0;
    force_empty = 0; armed = 0; inflight_prev = 0; model_cnt = 0; cycle_no = 0;
    prev_mv = 0; prev_rdy = 0; prev_flush = 0; prev_md = '0;

    // Reset values.
    #2;
    chk("rst_m_valid", 64'(bus.m_valid), 64'(0));
    chk("rst_rd_en", 64'(bus.fifo_rd_en), 64'(0));
    chk("rst_pop_cnt", 64'(bus.pop_cnt), 64'(0));
    chk("rst_m_data", 64'(bus.m_data), 64'(0));
    for (int i = 1; i <= 8; i++) fifo_q.push_back(32'(i));
    cyc();
    cyc();

    // Stream of 8 preloaded words with m_ready held high.
    bus.m_ready = 1'b1;
    rst_n = 1'b1;
    first_rd = -1; first_mv = -1; first_hs = -1; last_hs_c = -1; n_hs = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (last_rd && first_rd < 0) first_rd = cycle_no;
      if (last_mv && first_mv < 0) first_mv = cycle_no;
      if (last_hs) begin
        if (first_hs < 0) first_hs = cycle_no;
        last_hs_c = cycle_no;
        n_hs++;
      end
    end
    chk("fill_latency", 64'(first_mv - first_rd), 64'(2));
    chk("stream_words", 64'(n_hs), 64'(8));
    chk("stream_back2back", 64'(last_hs_c - first_hs), 64'(7));
    chk("stream_pop_cnt", 64'(bus.pop_cnt), 64'(8));

    // Backpressure: 4 words, consumer stalled for 10 cycles.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_q.push_back($urandom);
    bp0 = fifo_q[0];
    n_rd = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      n_rd += int'(last_rd);
    end
    chk("bp_rd_pulses", 64'(n_rd), 64'(2));
    chk("bp_head", 64'(bus.m_data), 64'(bp0));
    bus.m_ready = 1'b1;
    for (int c = 0; c < 8; c++) cyc();
    chk("bp_pop_cnt", 64'(bus.pop_cnt), 64'(12));

    // Flush one cycle after a read, with two words held.
    for (int i = 0; i < 4; i++) fifo_q.push_back($urandom);
    bus.m_ready = 1'b0;
    for (int c = 0; c < 4; c++) cyc();
    bus.m_ready = 1'b1;
    cyc();
    cnt_before = 13;
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    bus.m_ready = 1'b0;
    chk("flush_m_valid", 64'(bus.m_valid), 64'(0));
    chk("flush_pop_cnt", 64'(bus.pop_cnt), 64'(cnt_before));
    cyc();
    chk("flush_drop", 64'(bus.m_valid), 64'(0));
    bus.m_ready = 1'b1;
    for (int c = 0; c < 6; c++) cyc();

    // Reset pulled between edges while two words are buffered.
    for (int i = 0; i < 3; i++) fifo_q.push_back($urandom);
    bus.m_ready = 1'b0;
    for (int c = 0; c < 4; c++) cyc();
    chk("pre_rst_m_valid", 64'(bus.m_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 64'(bus.m_valid), 64'(0));
    chk("mid_rst_rd_en", 64'(bus.fifo_rd_en), 64'(0));
    chk("mid_rst_pop_cnt", 64'(bus.pop_cnt), 64'(0));
    chk("mid_rst_m_data", 64'(bus.m_data), 64'(0));
    held.delete(); model_cnt = 0; inflight_prev = 0; prev_mv = 0; armed = 0;
    cyc();
    cyc();
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 6; c++) cyc();

    // Alternating m_ready with 6 words.
    for (int i = 0; i < 6; i++) fifo_q.push_back($urandom);
    for (int c = 0; c < 20; c++) begin
      bus.m_ready = (c % 2 == 0);
      cyc();
    end
    chk("toggle_pop_cnt", 64'(bus.pop_cnt), 64'(7));

    // Random traffic with stalls, flushes and empty-flag glitches.
    for (int c = 0; c < 400; c++) begin
      if ($urandom % 3 == 0) fifo_q.push_back($urandom);
      bus.m_ready = ($urandom % 4 != 0);
      bus.flush   = ($urandom % 20 == 0);
      force_empty = ($urandom % 6 == 0);
      cyc();
    end
    bus.flush = 1'b0; force_empty = 0; bus.m_ready = 1'b1;
    for (int c = 0; c < 200 && (fifo_q.size() > 0 || held.size() > 0); c++) cyc();
    chk("drain_left", 64'(fifo_q.size() + held.size()), 64'(0));
    chk("drain_pop_cnt", 64'(bus.pop_cnt), 64'(model_cnt % 65536));

    // Counter wrap on the 4-bit instance: 17 handshakes leave 1.
    bus4.fifo_empty = 1'b0;
    bus4.m_ready = 1'b1;
    rst4_n = 1'b1;
    n4 = 0;
    for (int c = 0; c < 100 && n4 < 17; c++) begin
      @(negedge clk);
      if (bus4.m_valid && bus4.m_ready) n4++;
      bus4.fifo_rdata = 8'($urandom);
    end
    @(posedge clk);
    #1;
    bus4.m_ready = 1'b0;
    chk("wrap_handshakes", 64'(n4), 64'(17));
    chk("wrap_pop_cnt", 64'(bus4.pop_cnt), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
